// File: rtl/countdown_timer_if.sv
// ---------------------------------------------------------------------------
// countdown_timer_if
//
// Purpose:
//   Groups the command, preset and status signals of the MM:SS countdown
//   timer so the controller side and the timer can be connected as one bundle.
//
// Signals:
//   tick            one-cycle count enable (1 Hz strobe)
//   load            capture load_* digits as preset and current count
//   load_min_tens   preset minutes tens  (4-bit BCD)
//   load_min_ones   preset minutes ones  (4-bit BCD)
//   load_sec_tens   preset seconds tens  (4-bit BCD)
//   load_sec_ones   preset seconds ones  (4-bit BCD)
//   start           start / resume the countdown
//   pause           suspend the countdown
//   clear           abort, zero the count, return to idle
//   min_tens .. sec_ones   current count digits
//   running         high while counting
//   expired         high while latched at 00:00
//   done            one-cycle pulse on reaching 00:00
//   borrow_out      one-cycle pulse when the seconds wrap 00 -> 59
//
// Modports:
//   master  drives commands and presets, observes the count and status
//   slave   the timer itself
// ---------------------------------------------------------------------------
interface countdown_timer_if;

   logic       tick;
   logic       load;
   logic [3:0] load_min_tens;
   logic [3:0] load_min_ones;
   logic [3:0] load_sec_tens;
   logic [3:0] load_sec_ones;
   logic       start;
   logic       pause;
   logic       clear;

   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       running;
   logic       expired;
   logic       done;
   logic       borrow_out;

   modport master (
      output tick, load, load_min_tens, load_min_ones, load_sec_tens,
             load_sec_ones, start, pause, clear,
      input  min_tens, min_ones, sec_tens, sec_ones, running, expired,
             done, borrow_out
   );

   modport slave (
      input  tick, load, load_min_tens, load_min_ones, load_sec_tens,
             load_sec_ones, start, pause, clear,
      output min_tens, min_ones, sec_tens, sec_ones, running, expired,
             done, borrow_out
   );

endinterface

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//
// Purpose:
//   Loadable MM:SS BCD countdown timer. Each tick while running decrements
//   the count by one second, borrowing ones -> tens -> minutes. Reaching
//   00:00 pulses done and latches expiry; a seconds wrap (xx:00 -> xx:59)
//   pulses borrow_out for downstream display/alarm logic.
//
// Ports:
//   clk    system clock, all logic on the rising edge
//   rst_n  synchronous active-low reset
//   bus    countdown_timer_if.slave: commands, preset digits, count, status
//
// Parameters:
//   SEC_TENS_MAX  largest seconds-tens digit; a seconds borrow reloads it
//   MIN_TENS_MAX  largest minutes-tens digit accepted at load
//
// Build option:
//   AUTO_RELOAD_EN  when defined, expiry reloads the preset and keeps
//                   counting instead of latching at 00:00 (unless the
//                   preset itself is 00:00).
// ---------------------------------------------------------------------------
module countdown_timer #(
   parameter logic [3:0] SEC_TENS_MAX = 4'd5,
   parameter logic [3:0] MIN_TENS_MAX = 4'd9
) (
   input  logic             clk,
   input  logic             rst_n,
   countdown_timer_if.slave bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0] state_q, state_d;

   logic [3:0] minTens_q, minTens_d;
   logic [3:0] minOnes_q, minOnes_d;
   logic [3:0] secTens_q, secTens_d;
   logic [3:0] secOnes_q, secOnes_d;

   logic [3:0] preMinTens_q, preMinTens_d;
   logic [3:0] preMinOnes_q, preMinOnes_d;
   logic [3:0] preSecTens_q, preSecTens_d;
   logic [3:0] preSecOnes_q, preSecOnes_d;

   logic done_q, done_d;
   logic borrow_q, borrow_d;

   logic [3:0] clMinTens, clMinOnes, clSecTens, clSecOnes;
   logic [3:0] decMinTens, decMinOnes, decSecTens, decSecOnes;
   logic       secOnesBorrow, secTensBorrow, minOnesBorrow;
   logic       countIsZero, decIsZero;
   logic       loadOk, pauseOk, startOk, tickOk;

   function automatic logic [3:0] clampDigit(input logic [3:0] v,
                                             input logic [3:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   // Preset digits are clamped per digit so an illegal BCD preset can never
   // put the counter into a state the borrow chain cannot walk back from.
   always_comb begin
      clMinTens = clampDigit(bus.load_min_tens, MIN_TENS_MAX);
      clMinOnes = clampDigit(bus.load_min_ones, 4'd9);
      clSecTens = clampDigit(bus.load_sec_tens, SEC_TENS_MAX);
      clSecOnes = clampDigit(bus.load_sec_ones, 4'd9);
   end

   // One-second decrement with the borrow rippling from the seconds ones
   // digit up to the minutes tens digit. The count is never 00:00 while
   // running, so minutes tens cannot underflow.
   always_comb begin
      secOnesBorrow = (secOnes_q == 4'd0);
      secTensBorrow = secOnesBorrow && (secTens_q == 4'd0);
      minOnesBorrow = secTensBorrow && (minOnes_q == 4'd0);

      decSecOnes = secOnesBorrow ? 4'd9 : (secOnes_q - 4'd1);
      decSecTens = secTens_q;
      decMinOnes = minOnes_q;
      decMinTens = minTens_q;
      if (secOnesBorrow) begin
         decSecTens = (secTens_q == 4'd0) ? SEC_TENS_MAX : (secTens_q - 4'd1);
      end
      if (secTensBorrow) begin
         decMinOnes = (minOnes_q == 4'd0) ? 4'd9 : (minOnes_q - 4'd1);
      end
      if (minOnesBorrow) begin
         decMinTens = minTens_q - 4'd1;
      end

      countIsZero = ({minTens_q, minOnes_q, secTens_q, secOnes_q} == 16'h0000);
      decIsZero   = ({decMinTens, decMinOnes, decSecTens, decSecOnes} == 16'h0000);
   end

   // A command that is ignored in the current state does not block the
   // lower-priority commands below it; each qualifier already includes the
   // state in which the command is meaningful.
   always_comb begin
      loadOk  = bus.load  && ((state_q == ST_IDLE) || (state_q == ST_DONE));
      pauseOk = bus.pause && (state_q == ST_RUN);
      startOk = bus.start && (((state_q == ST_IDLE) && !countIsZero) ||
                              (state_q == ST_PAUSE));
      tickOk  = bus.tick  && (state_q == ST_RUN);
   end

   // Next-state logic, priority clear > load > pause > start > tick.
   // done and borrow_out default low so they can only ever be single-cycle.
   always_comb begin
      state_d      = state_q;
      minTens_d    = minTens_q;
      minOnes_d    = minOnes_q;
      secTens_d    = secTens_q;
      secOnes_d    = secOnes_q;
      preMinTens_d = preMinTens_q;
      preMinOnes_d = preMinOnes_q;
      preSecTens_d = preSecTens_q;
      preSecOnes_d = preSecOnes_q;
      done_d       = 1'b0;
      borrow_d     = 1'b0;

      if (bus.clear) begin
         state_d   = ST_IDLE;
         minTens_d = 4'd0;
         minOnes_d = 4'd0;
         secTens_d = 4'd0;
         secOnes_d = 4'd0;
      end else if (loadOk) begin
         state_d      = ST_IDLE;
         minTens_d    = clMinTens;
         minOnes_d    = clMinOnes;
         secTens_d    = clSecTens;
         secOnes_d    = clSecOnes;
         preMinTens_d = clMinTens;
         preMinOnes_d = clMinOnes;
         preSecTens_d = clSecTens;
         preSecOnes_d = clSecOnes;
      end else if (pauseOk) begin
         state_d = ST_PAUSE;
      end else if (startOk) begin
         state_d = ST_RUN;
      end else if (tickOk) begin
         minTens_d = decMinTens;
         minOnes_d = decMinOnes;
         secTens_d = decSecTens;
         secOnes_d = decSecOnes;
         if (decIsZero) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
`ifdef AUTO_RELOAD_EN
            // A 00:00 preset would reload straight into expiry, so it
            // latches DONE exactly as the non-reloading build does.
            if ({preMinTens_q, preMinOnes_q, preSecTens_q, preSecOnes_q} != 16'h0000) begin
               state_d   = ST_RUN;
               minTens_d = preMinTens_q;
               minOnes_d = preMinOnes_q;
               secTens_d = preSecTens_q;
               secOnes_d = preSecOnes_q;
            end
`endif
         end else begin
            borrow_d = secTensBorrow;
         end
      end
   end

   // State, count, preset and pulse registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         minTens_q    <= 4'd0;
         minOnes_q    <= 4'd0;
         secTens_q    <= 4'd0;
         secOnes_q    <= 4'd0;
         preMinTens_q <= 4'd0;
         preMinOnes_q <= 4'd0;
         preSecTens_q <= 4'd0;
         preSecOnes_q <= 4'd0;
         done_q       <= 1'b0;
         borrow_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         minTens_q    <= minTens_d;
         minOnes_q    <= minOnes_d;
         secTens_q    <= secTens_d;
         secOnes_q    <= secOnes_d;
         preMinTens_q <= preMinTens_d;
         preMinOnes_q <= preMinOnes_d;
         preSecTens_q <= preSecTens_d;
         preSecOnes_q <= preSecOnes_d;
         done_q       <= done_d;
         borrow_q     <= borrow_d;
      end
   end

   assign bus.min_tens   = minTens_q;
   assign bus.min_ones   = minOnes_q;
   assign bus.sec_tens   = secTens_q;
   assign bus.sec_ones   = secOnes_q;
   assign bus.running    = (state_q == ST_RUN);
   assign bus.expired    = (state_q == ST_DONE);
   assign bus.done       = done_q;
   assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer
//
// Purpose:
//   Directed self-checking bench for countdown_timer. Count digits are
//   observed as one 16-bit BCD word MM:SS and the status as the 4-bit word
//   {running, expired, done, borrow_out}.
//
// Build option:
//   AUTO_RELOAD_EN  selects the auto-reload expectations and scenario.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

   logic clk;
   logic rst_n;
   int   compared;
   int   mismatched;

   countdown_timer_if bus();

   countdown_timer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [15:0] countObs;
   logic [3:0]  statusObs;
   assign countObs  = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
   assign statusObs = {bus.running, bus.expired, bus.done, bus.borrow_out};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Holds the given commands across one rising edge, then drops them and
   // leaves the bench 1 time unit after the edge, where outputs are sampled.
   task automatic step(input logic t, input logic s, input logic p,
                       input logic l, input logic c);
      bus.tick  = t;
      bus.start = s;
      bus.pause = p;
      bus.load  = l;
      bus.clear = c;
      @(posedge clk);
      #1;
      bus.tick  = 1'b0;
      bus.start = 1'b0;
      bus.pause = 1'b0;
      bus.load  = 1'b0;
      bus.clear = 1'b0;
   endtask

   task automatic setLoad(input logic [15:0] v);
      bus.load_min_tens = v[15:12];
      bus.load_min_ones = v[11:8];
      bus.load_sec_tens = v[7:4];
      bus.load_sec_ones = v[3:0];
   endtask

   // Reset is held with every command high; reset must win over all of them.
   task automatic test_reset();
      rst_n = 1'b0;
      setLoad(16'h1234);
      bus.tick  = 1'b1;
      bus.start = 1'b1;
      bus.load  = 1'b1;
      bus.pause = 1'b0;
      bus.clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      compared++;
      if (countObs !== 16'h0000) begin
         mismatched++;
         $display("[TB] FAIL reset_count: got %h, expected %h", countObs, 16'h0000);
      end
      compared++;
      if (statusObs !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL reset_status: got %b, expected %b", statusObs, 4'b0000);
      end
      rst_n = 1'b1;
      bus.tick  = 1'b0;
      bus.start = 1'b0;
      bus.load  = 1'b0;
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      compared++;
      if (statusObs !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL reset_start_zero: got %b, expected %b", statusObs, 4'b0000);
      end
   endtask

   // 01:00 down to expiry: first tick wraps the seconds and pulses borrow_out.
   task automatic test_countdown();
      logic sawPulse;
      setLoad(16'h0100);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      compared++;
      if (countObs !== 16'h0100) begin
         mismatched++;
         $display("[TB] FAIL cd_load_count: got %h, expected %h", countObs, 16'h0100);
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      compared++;
      if (statusObs !== 4'b1000) begin
         mismatched++;
         $display("[TB] FAIL cd_start_status: got %b, expected %b", statusObs, 4'b1000);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      compared++;
      if (countObs !== 16'h0059) begin
         mismatched++;
         $display("[TB] FAIL cd_first_tick_count: got %h, expected %h", countObs, 16'h0059);
      end
      compared++;
      if (statusObs !== 4'b1001) begin
         mismatched++;
         $display("[TB] FAIL cd_borrow_pulse: got %b, expected %b", statusObs, 4'b1001);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      compared++;
      if (statusObs !== 4'b1000) begin
         mismatched++;
         $display("[TB] FAIL cd_borrow_one_cycle: got %b, expected %b", statusObs, 4'b1000);
      end
      sawPulse = 1'b0;
      for (int i = 0; i < 58; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         if (bus.done || bus.borrow_out) sawPulse = 1'b1;
      end
      compared++;
      if (countObs !== 16'h0001) begin
         mismatched++;
         $display("[TB] FAIL cd_count_0001: got %h, expected %h", countObs, 16'h0001);
      end
      compared++;
      if (sawPulse !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL cd_no_stray_pulse: got %b, expected %b", sawPulse, 1'b0);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef AUTO_RELOAD_EN
      compared++;
      if (countObs !== 16'h0100) begin
         mismatched++;
         $display("[TB] FAIL cd_expiry_reload: got %h, expected %h", countObs, 16'h0100);
      end
      compared++;
      if (statusObs !== 4'b1010) begin
         mismatched++;
         $display("[TB] FAIL cd_expiry_status: got %b, expected %b", statusObs, 4'b1010);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`else
      compared++;
      if (countObs !== 16'h0000) begin
         mismatched++;
         $display("[TB] FAIL cd_expiry_count: got %h, expected %h", countObs, 16'h0000);
      end
      compared++;
      if (statusObs !== 4'b0110) begin
         mismatched++;
         $display("[TB] FAIL cd_expiry_status: got %b, expected %b", statusObs, 4'b0110);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      compared++;
      if (statusObs !== 4'b0100) begin
         mismatched++;
         $display("[TB] FAIL cd_done_one_cycle: got %b, expected %b", statusObs, 4'b0100);
      end
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      compared++;
      if ({countObs, statusObs} !== {16'h0000, 4'b0100}) begin
         mismatched++;
         $display("[TB] FAIL cd_done_holds: got %h, expected %h", {countObs, statusObs}, {16'h0000, 4'b0100});
      end
`endif
   endtask

   // Illegal preset digits clamp; a zero preset cannot be started.
   task automatic test_clamp();
      setLoad(16'hAB7C);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      compared++;
      if (countObs !== 16'h9959) begin
         mismatched++;
         $display("[TB] FAIL clamp_count: got %h, expected %h", countObs, 16'h9959);
      end
      compared++;
      if (statusObs !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL clamp_status: got %b, expected %b", statusObs, 4'b0000);
      end
      setLoad(16'h0000);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      compared++;
      if ({countObs, statusObs} !== {16'h0000, 4'b0000}) begin
         mismatched++;
         $display("[TB] FAIL clamp_zero_start: got %h, expected %h", {countObs, statusObs}, {16'h0000, 4'b0000});
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      compared++;
      if (statusObs !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL clamp_zero_no_done: got %b, expected %b", statusObs, 4'b0000);
      end
   endtask

   // Pause beats a simultaneous tick; ticks in PAUSE are ignored.
   task automatic test_pause();
      setLoad(16'h0005);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      compared++;
      if (countObs !== 16'h0005) begin
         mismatched++;
         $display("[TB] FAIL pause_tick_dropped: got %h, expected %h", countObs, 16'h0005);
      end
      compared++;
      if (statusObs !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL pause_status: got %b, expected %b", statusObs, 4'b0000);
      end
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      compared++;
      if (countObs !== 16'h0005) begin
         mismatched++;
         $display("[TB] FAIL pause_ticks_ignored: got %h, expected %h", countObs, 16'h0005);
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      compared++;
      if (statusObs !== 4'b1000) begin
         mismatched++;
         $display("[TB] FAIL pause_resume: got %b, expected %b", statusObs, 4'b1000);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      compared++;
      if (countObs !== 16'h0004) begin
         mismatched++;
         $display("[TB] FAIL pause_resume_tick: got %h, expected %h", countObs, 16'h0004);
      end
   endtask

   // Load is ignored while running; clear zeroes the count and idles.
   task automatic test_load_clear();
      repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      setLoad(16'h0300);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      compared++;
      if ({countObs, statusObs} !== {16'h0002, 4'b1000}) begin
         mismatched++;
         $display("[TB] FAIL load_ignored_run: got %h, expected %h", {countObs, statusObs}, {16'h0002, 4'b1000});
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      compared++;
      if ({countObs, statusObs} !== {16'h0000, 4'b0000}) begin
         mismatched++;
         $display("[TB] FAIL clear_result: got %h, expected %h", {countObs, statusObs}, {16'h0000, 4'b0000});
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      compared++;
      if (statusObs !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL clear_start_idle: got %b, expected %b", statusObs, 4'b0000);
      end
   endtask

   // Borrow through minutes tens, a non-wrapping tens borrow, and a tick in IDLE.
   task automatic test_borrow_chain();
      setLoad(16'h1000);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      compared++;
      if ({countObs, statusObs} !== {16'h1000, 4'b0000}) begin
         mismatched++;
         $display("[TB] FAIL chain_idle_tick: got %h, expected %h", {countObs, statusObs}, {16'h1000, 4'b0000});
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      compared++;
      if ({countObs, statusObs} !== {16'h0959, 4'b1001}) begin
         mismatched++;
         $display("[TB] FAIL chain_min_tens: got %h, expected %h", {countObs, statusObs}, {16'h0959, 4'b1001});
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      setLoad(16'h0010);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      compared++;
      if ({countObs, statusObs} !== {16'h0009, 4'b1000}) begin
         mismatched++;
         $display("[TB] FAIL chain_sec_tens: got %h, expected %h", {countObs, statusObs}, {16'h0009, 4'b1000});
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

`ifdef AUTO_RELOAD_EN
   // Expiry reloads the preset, keeps running and pulses done each period.
   task automatic test_auto_reload();
      setLoad(16'h0002);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      compared++;
      if ({countObs, statusObs} !== {16'h0002, 4'b1010}) begin
         mismatched++;
         $display("[TB] FAIL reload_first: got %h, expected %h", {countObs, statusObs}, {16'h0002, 4'b1010});
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      compared++;
      if ({countObs, statusObs} !== {16'h0001, 4'b1000}) begin
         mismatched++;
         $display("[TB] FAIL reload_counting: got %h, expected %h", {countObs, statusObs}, {16'h0001, 4'b1000});
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      compared++;
      if ({countObs, statusObs} !== {16'h0002, 4'b1010}) begin
         mismatched++;
         $display("[TB] FAIL reload_second: got %h, expected %h", {countObs, statusObs}, {16'h0002, 4'b1010});
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask
`endif

   initial begin
      compared   = 0;
      mismatched = 0;
      rst_n      = 1'b0;
      bus.tick   = 1'b0;
      bus.start  = 1'b0;
      bus.pause  = 1'b0;
      bus.load   = 1'b0;
      bus.clear  = 1'b0;
      setLoad(16'h0000);

      test_reset();
      test_countdown();
      test_clamp();
      test_pause();
      test_load_clear();
      test_borrow_chain();
`ifdef AUTO_RELOAD_EN
      test_auto_reload();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable MM:SS BCD countdown timer, the decrementing counterpart of the timer block's up-counting modulo-6/modulo-10 digit counters.
- Decrements once per `tick` enable and propagates borrows ones→tens→minutes.
- Signals expiry and a per-minute borrow pulse to downstream display and alarm logic.
- Sits in the timer subsystem between the 1 Hz tick generator and the 7-segment driver.

Parameters:
SEC_TENS_MAX, 5, maximum seconds-tens digit; borrow reloads this value (wrap 0→5).
MIN_TENS_MAX, 9, maximum minutes-tens digit accepted at load (clamp limit).

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
tick  input  1  one-cycle count enable (1 Hz strobe)
load  input  1  capture load_* digits as preset and current count
load_min_tens  input  4  preset minutes tens
load_min_ones  input  4  preset minutes ones
load_sec_tens  input  4  preset seconds tens
load_sec_ones  input  4  preset seconds ones
start  input  1  start/resume countdown
pause  input  1  suspend countdown
clear  input  1  abort; zero count, return to IDLE
min_tens  output  4  current minutes tens
min_ones  output  4  current minutes ones
sec_tens  output  4  current seconds tens
sec_ones  output  4  current seconds ones
running  output  1  high in RUN
expired  output  1  high in DONE
done  output  1  one-cycle pulse on reaching 00:00
borrow_out  output  1  one-cycle pulse when seconds wrap 00→SEC_TENS_MAX9

Behaviour:
- Reset (rst_n low at clk edge; synchronous only):
  - All digits and preset registers = 0.
  - State IDLE; running = expired = done = borrow_out = 0.
- All outputs are registered.
- States: IDLE, RUN, PAUSE, DONE.
- Priority each cycle: clear > load > pause > start > tick.
- clear (any state): next state IDLE, digits = 0, preset unchanged, pulses 0.
- load:
  - Accepted only in IDLE or DONE; ignored in RUN and PAUSE.
  - Captures preset and current count; next state IDLE.
  - Clamping, applied per digit: ones >9 → 9; sec_tens >SEC_TENS_MAX → SEC_TENS_MAX; min_tens >MIN_TENS_MAX → MIN_TENS_MAX.
- start:
  - IDLE, count ≠ 0 → RUN.
  - IDLE, count = 0 → stays IDLE, no done.
  - PAUSE → RUN.
  - Ignored in RUN and DONE.
- pause: RUN → PAUSE. A tick in the same cycle is dropped.
- tick in RUN, one decrement; new digits visible the cycle after the tick:
  - sec_ones 0→9 with borrow, else −1.
  - sec_tens, on borrow: 0→SEC_TENS_MAX with borrow, else −1.
  - min_ones, on borrow: 0→9 with borrow, else −1.
  - min_tens, on borrow: −1.
  - borrow_out = 1 for the cycle in which a seconds wrap is registered, i.e. a sec_tens borrow occurred.
- Expiry: a tick that makes the count 00:00 has the following effects in the same registered update:
  - done = 1 for one cycle.
  - State DONE, expired = 1.
  - borrow_out = 0.
- tick outside RUN: ignored.
- DONE holds 00:00 and expired = 1 until load or clear.
- Register updates:
  - done and borrow_out are never high for more than one cycle.
  - running and expired are decoded from registered state.
- rst_n low mid-count has priority over every input; next cycle as reset.

Optional Feature:
AUTO_RELOAD_EN:
- Defined:
  - Expiry tick still pulses done for one cycle.
  - Count is reloaded from the preset instead of 00:00, and state stays RUN; DONE is never entered and expired stays 0.
  - A preset of 00:00 behaves as if the macro were undefined.
- Undefined: behaviour as above, with DONE latched.

Test Plan:
- Reset: rst_n=0 for 2 cycles with tick, start, and load all high → digits 00:00, state IDLE, all outputs 0.
- Load 01:00 → start → one tick → 00:59 with borrow_out pulse of exactly 1 cycle; 59 further ticks → 00:00, done 1 cycle, expired=1, running=0.
- Load illegal A:B:7:C → clamped to 9:9:5:9 (SEC_TENS_MAX=5). Load 00:00 then start → remains IDLE with no done.
- RUN at 00:05 → pause and tick in the same cycle → count stays 00:05, state PAUSE. Then ticks ×3 → no change. Then start, tick → 00:04.
- RUN at 00:02 → load 03:00 → ignored. Then clear → 00:00, IDLE, preset retained; start → stays IDLE.
- AUTO_RELOAD_EN defined, preset 00:02, start, ticks ×2 → done pulse, count 00:02, running=1, expired=0; ticks ×2 more → second done pulse.
